// File: rtl/cpu_mem_defs.sv
// Shared definitions for the memory arbiter slice.
// Contents: default bus widths and burst limit, the arbiter FSM state
// encoding, and the grant codes shown on the debug grant port.
package cpu_mem_defs;

    localparam int unsigned ADDR_W_DEF    = 8;
    localparam int unsigned DATA_W_DEF    = 8;
    localparam int unsigned MAX_BURST_DEF = 4;

    // Each access takes two cycles: an ACC cycle (address/write) and then an RSP cycle (data/ack).
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CPU_ACC = 3'd1,
        ST_CPU_RSP = 3'd2,
        ST_DMA_ACC = 3'd3,
        ST_DMA_RSP = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'b00,
        GNT_CPU  = 2'b01,
        GNT_DMA  = 2'b10
    } grant_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker with a DMA lock override. Purely combinational.
// Ports:
//   cpu_req, dma_req : pending requests
//   last_grant       : owner of the most recently completed access
//   lock             : DMA burst lock; DMA wins when it is set and DMA is requesting
//   pick_c           : one-hot pick, bit 0 = CPU, bit 1 = DMA, all zero = none
module rr_pick2
    import cpu_mem_defs::*;
(
    input  logic       cpu_req,
    input  logic       dma_req,
    input  grant_t     last_grant,
    input  logic       lock,
    output logic [1:0] pick_c
);

    always_comb begin
        pick_c = 2'b00;
        if (lock && dma_req) begin
            pick_c = 2'b10;
        end else if (cpu_req && dma_req) begin
            // On a tie, the requester that was not served last wins.
            pick_c = (last_grant == GNT_CPU) ? 2'b10 : 2'b01;
        end else if (cpu_req) begin
            pick_c = 2'b01;
        end else if (dma_req) begin
            pick_c = 2'b10;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter that lets the CPU path and a DMA/loader port share one synchronous-read memory.
// Every access is an ACC cycle followed by an RSP cycle. Arbitration is round-robin,
// and a DMA burst may lock the memory for at most MAX_BURST beats.
// Ports:
//   Clk, Reset                     : clock, asynchronous active-high reset
//   cpu_req/addr/wdata/write       : CPU request, held until cpu_ack
//   cpu_rdata, cpu_ack             : CPU read data (live in RSP, held afterwards), completion strobe
//   dma_req/addr/wdata/write/last  : DMA request, held until dma_ack; last ends a burst
//   dma_rdata, dma_ack             : DMA read data, completion strobe
//   mem_addr/wdata/write, mem_rdata: memory interface; read data arrives one cycle after the address
//   grant                          : current owner (debug)
module mem_arbiter
    import cpu_mem_defs::*;
#(
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_write,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    input  logic              dma_req,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    input  logic              dma_write,
    input  logic              dma_last,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        grant
);

    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    state_t              state, state_d;
    grant_t              last_grant, last_grant_d;
    logic                lock, lock_d;
    logic [CNT_W-1:0]    burst_cnt, burst_cnt_d;
    logic [CNT_W-1:0]    burst_inc_c;
    logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0]   dma_rdata_q, dma_rdata_d;
    logic [1:0]          pick_c;

    rr_pick2 u_pick (
        .cpu_req    (cpu_req),
        .dma_req    (dma_req),
        .last_grant (last_grant),
        .lock       (lock),
        .pick_c     (pick_c)
    );

    assign burst_inc_c = burst_cnt + CNT_W'(1);

    // State register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Arbitration history, burst lock and read-data holding registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            last_grant  <= GNT_DMA;
            lock        <= 1'b0;
            burst_cnt   <= '0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            last_grant  <= last_grant_d;
            lock        <= lock_d;
            burst_cnt   <= burst_cnt_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
        end
    end

    // Next-state, register updates and memory/requester outputs
    always_comb begin
        state_d      = state;
        last_grant_d = last_grant;
        lock_d       = lock;
        burst_cnt_d  = burst_cnt;
        cpu_rdata_d  = cpu_rdata_q;
        dma_rdata_d  = dma_rdata_q;
        mem_addr     = '0;
        mem_wdata    = '0;
        mem_write    = 1'b0;
        grant        = GNT_NONE;
        cpu_ack      = 1'b0;
        dma_ack      = 1'b0;
        cpu_rdata    = cpu_rdata_q;
        dma_rdata    = dma_rdata_q;

        unique case (state)
            ST_IDLE: begin
                // When the lock holder stops requesting, the burst is released. The picker
                // then arbitrates normally in this same cycle.
                if (lock && !dma_req) begin
                    lock_d      = 1'b0;
                    burst_cnt_d = '0;
                end
                if (pick_c[1]) begin
                    state_d = ST_DMA_ACC;
                end else if (pick_c[0]) begin
                    state_d = ST_CPU_ACC;
                end
            end
            ST_CPU_ACC: begin
                grant     = GNT_CPU;
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
                mem_write = cpu_write;
                state_d   = ST_CPU_RSP;
            end
            ST_CPU_RSP: begin
                grant        = GNT_CPU;
                cpu_ack      = 1'b1;
                last_grant_d = GNT_CPU;
                state_d      = ST_IDLE;
                if (!cpu_write) begin
                    cpu_rdata   = mem_rdata;
                    cpu_rdata_d = mem_rdata;
                end
            end
            ST_DMA_ACC: begin
                grant     = GNT_DMA;
                mem_addr  = dma_addr;
                mem_wdata = dma_wdata;
                mem_write = dma_write;
                state_d   = ST_DMA_RSP;
            end
            ST_DMA_RSP: begin
                grant        = GNT_DMA;
                dma_ack      = 1'b1;
                last_grant_d = GNT_DMA;
                state_d      = ST_IDLE;
                if (!dma_write) begin
                    dma_rdata   = mem_rdata;
                    dma_rdata_d = mem_rdata;
                end
                // The lock stays set while the burst continues and stays under MAX_BURST beats.
                if (!dma_last && (32'(burst_inc_c) < MAX_BURST)) begin
                    lock_d      = 1'b1;
                    burst_cnt_d = burst_inc_c;
                end else begin
                    lock_d      = 1'b0;
                    burst_cnt_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
